// File: rtl/conv_3x3_weight_streamer.sv
// Streams NUM_KERNELS 3x3 kernels from a 1-cycle-latency weight RAM as contiguous valid bursts,
// and answers conv-engine load requests only for kernels that have settled in the weight buffer.
module conv_3x3_weight_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int KERNEL_SIZE = 9,
  parameter int CNT_WIDTH   = 4,
  parameter int NUM_KERNELS = 16,
  parameter int KCNT_WIDTH  = 5,
  parameter int GAP_CYCLES  = 1,
  parameter int SETTLE      = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  valid_out_o,
  output logic [DATA_WIDTH-1:0] out_o,
  input  logic                  load_req_i,
  output logic                  load_weights_o,
  output logic                  load_drop_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [KCNT_WIDTH:0] PEND_MAX = (KCNT_WIDTH + 1)'(NUM_KERNELS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_GAP, S_DRAIN} state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_WIDTH-1:0]    beat_q;
  logic [KCNT_WIDTH-1:0]   kidx_q;
  logic [GW-1:0]           gap_q;
  logic [1:0]              drain_q;
  logic                    rd_en_q;
  logic                    busy_q;
  logic                    done_q;

  logic                    rd_d1_q;
  logic                    valid_q;
  logic [DATA_WIDTH-1:0]   out_q;
  logic                    last_d1_q;
  logic                    last_d2_q;
  logic                    rd_last;

  logic [SETTLE-1:0]       settle_q;
  logic [SETTLE-1:0]       settle_d;
  logic [KCNT_WIDTH-1:0]   pending_q;
  logic [KCNT_WIDTH-1:0]   pending_d;
  logic [KCNT_WIDTH:0]     pend_sum;
  logic                    emerge;
  logic                    accept;
  logic                    load_weights_q;
  logic                    load_drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      kidx_q  <= '0;
      gap_q   <= '0;
      drain_q <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (done_q) busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            addr_q  <= base_addr_i;
            beat_q  <= '0;
            kidx_q  <= '0;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_FETCH: begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          if (beat_q == CNT_WIDTH'(KERNEL_SIZE - 1)) begin
            beat_q  <= '0;
            rd_en_q <= 1'b0;
            if (kidx_q == KCNT_WIDTH'(NUM_KERNELS - 1)) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= '0;
              kidx_q  <= kidx_q + KCNT_WIDTH'(1);
            end
          end else begin
            beat_q <= beat_q + CNT_WIDTH'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= S_FETCH;
            rd_en_q <= 1'b1;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_DRAIN: begin
          // Wait until the final read has left valid_out before signalling completion.
          if (drain_q == 2'd2) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_last = (state_q == S_FETCH) && (beat_q == CNT_WIDTH'(KERNEL_SIZE - 1));

  // Read pipe: the "last beat" flag travels alongside the strobe so it lines up with valid_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1_q   <= 1'b0;
      valid_q   <= 1'b0;
      out_q     <= '0;
      last_d1_q <= 1'b0;
      last_d2_q <= 1'b0;
    end else begin
      rd_d1_q   <= rd_en_q;
      valid_q   <= rd_d1_q;
      last_d1_q <= rd_last;
      last_d2_q <= last_d1_q;
      if (rd_d1_q) out_q <= mem_rdata_i;
    end
  end

  generate
    for (genvar gi = 0; gi < SETTLE; gi++) begin : g_settle
      if (gi == 0) begin : g_head
        assign settle_d[gi] = last_d2_q;
      end else begin : g_tail
        assign settle_d[gi] = settle_q[gi-1];
      end
    end
  endgenerate

  assign emerge = settle_q[SETTLE-1];
  assign accept = load_req_i && (pending_q != '0);

  always_comb begin
    pend_sum  = {1'b0, pending_q} + {{KCNT_WIDTH{1'b0}}, emerge} - {{KCNT_WIDTH{1'b0}}, accept};
    pending_d = pending_q;
    if (pend_sum > PEND_MAX) pending_d = PEND_MAX[KCNT_WIDTH-1:0];
    else                     pending_d = pend_sum[KCNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      settle_q       <= '0;
      pending_q      <= '0;
      load_weights_q <= 1'b0;
      load_drop_q    <= 1'b0;
    end else begin
      settle_q       <= settle_d;
      pending_q      <= pending_d;
      load_weights_q <= accept;
      load_drop_q    <= load_req_i && !accept;
    end
  end

  assign mem_rd_en_o    = rd_en_q;
  assign mem_addr_o     = addr_q;
  assign valid_out_o    = valid_q;
  assign out_o          = out_q;
  assign load_weights_o = load_weights_q;
  assign load_drop_o    = load_drop_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_conv_3x3_weight_streamer.sv
// Bench for conv_3x3_weight_streamer: burst timing/data, load handshake, address wrap, restart and abort.
module tb_conv_3x3_weight_streamer;

  localparam int K      = 9;
  localparam int N      = 16;
  localparam int G      = 1;
  localparam int S      = 12;
  localparam int PB     = K + G;
  localparam int LAST_T = 3 + PB * (N - 1) + K - 1;
  localparam int DONE_T = LAST_T + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        valid_out;
  logic [31:0] out_w;
  logic        load_req;
  logic        load_weights;
  logic        load_drop;
  logic        busy;
  logic        done;

  logic [31:0] ram [256];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_pend   = 0;
  logic [31:0] m_last_out = '0;

  typedef struct {
    bit req;
    bit exp_lw;
    bit exp_drop;
  } lvec_t;
  lvec_t tbl [20];

  conv_3x3_weight_streamer dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .mem_rd_en_o    (mem_rd_en),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .valid_out_o    (valid_out),
    .out_o          (out_w),
    .load_req_i     (load_req),
    .load_weights_o (load_weights),
    .load_drop_o    (load_drop),
    .busy_o         (busy),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_burst(input int t, input int lead, output int k, output int b);
    int tt;
    tt = t - lead;
    k = 0;
    b = 0;
    if (tt < 0) return 1'b0;
    k = tt / PB;
    b = tt % PB;
    return (k < N) && (b < K);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, " mem_rd_en"}, mem_rd_en, 0);
    chk({tag, " mem_addr"}, mem_addr, 0);
    chk({tag, " valid_out"}, valid_out, 0);
    chk({tag, " out"}, out_w, 0);
    chk({tag, " load_weights"}, load_weights, 0);
    chk({tag, " load_drop"}, load_drop, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
  endtask

  // One transfer, observed cycle by cycle against burst arithmetic and a pending-count model.
  task automatic run_transfer(input logic [7:0] base, input int ncyc, input int req_mode,
                              input int restart_t, input int abort_t);
    int k, b, tt;
    bit e_rd, e_v, req, emerge;
    bit exp_lw, exp_drop;
    string tg;
    exp_lw = 0;
    exp_drop = 0;
    start = 1'b1;
    base_addr = base;
    load_req = 1'b0;
    for (int t = 1; t <= ncyc; t++) begin
      step();
      tg = $sformatf("b%02h t%0d", base, t);
      if (abort_t != 0 && t == abort_t + 1) begin
        check_all_zero({tg, " after abort"});
        reset = 1'b0;
        m_pend = 0;
        m_last_out = '0;
        return;
      end
      e_rd = in_burst(t, 1, k, b);
      chk({tg, " mem_rd_en"}, mem_rd_en, e_rd);
      if (e_rd) chk({tg, " mem_addr"}, mem_addr, 8'(base + K * k + b));
      e_v = in_burst(t, 3, k, b);
      if (e_v) m_last_out = ram[8'(base + K * k + b)];
      chk({tg, " valid_out"}, valid_out, e_v);
      chk({tg, " out"}, out_w, m_last_out);
      chk({tg, " busy"}, busy, (t >= 1 && t <= DONE_T));
      chk({tg, " done"}, done, (t == DONE_T));
      chk({tg, " load_weights"}, load_weights, exp_lw);
      chk({tg, " load_drop"}, load_drop, exp_drop);

      if (abort_t != 0 && t == abort_t) begin
        reset = 1'b1;
        start = 1'b0;
        load_req = 1'b0;
        continue;
      end
      start = (t == restart_t);
      base_addr = 8'($urandom);
      if (req_mode == 0) req = (t == 12 || t == 24);
      else               req = ($urandom_range(3) == 0);
      if (t == ncyc) req = 1'b0;
      load_req = req;
      tt = t - (3 + K - 1 + S);
      emerge = (tt >= 0) && (tt % PB == 0) && (tt / PB < N);
      exp_lw = req && (m_pend > 0);
      exp_drop = req && !exp_lw;
      m_pend = m_pend + int'(emerge) - int'(exp_lw);
      if (m_pend > N) m_pend = N;
    end
    start = 1'b0;
    load_req = 1'b0;
  endtask

  initial begin
    int avail;
    avail = N - 1;
    for (int i = 0; i < 20; i++) begin
      tbl[i].req = (i != 5 && i != 9);
      tbl[i].exp_lw = tbl[i].req && (avail > 0);
      tbl[i].exp_drop = tbl[i].req && !tbl[i].exp_lw;
      if (tbl[i].exp_lw) avail--;
    end

    reset = 1'b1;
    start = 1'b0;
    load_req = 1'b0;
    base_addr = '0;
    for (int i = 0; i < 256; i++) ram[i] = i;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Identity RAM from 0x10, drop then accept, and a start pulse ignored mid-transfer.
    run_transfer(8'h10, 180, 0, 50, 0);

    // Drain the kernels left pending by the first transfer.
    for (int i = 0; i < 20; i++) begin
      load_req = tbl[i].req;
      step();
      chk($sformatf("table %0d load_weights", i), load_weights, tbl[i].exp_lw);
      chk($sformatf("table %0d load_drop", i), load_drop, tbl[i].exp_drop);
    end
    load_req = 1'b0;
    m_pend = avail;
    step();

    // Address wrap past 0xFF with random contents.
    for (int i = 0; i < 256; i++) ram[i] = $urandom;
    run_transfer(8'hF8, 180, 1, 0, 0);

    // Reset on the fifth beat of kernel 3.
    run_transfer(8'h10, 100, 1, 0, 3 + PB * 3 + 4);
    repeat (20) step();
    chk("post-abort idle load_weights", load_weights, 0);
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("post-abort load_drop", load_drop, 1);
    chk("post-abort load_weights", load_weights, 0);
    step();
    chk("post-abort drop clears", load_drop, 0);

    // Fresh transfer after the abort, random base and request traffic.
    run_transfer(8'h10, 180, 1, 0, 0);
    run_transfer(8'($urandom), 180, 1, $urandom_range(20, 150), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
